// File: rtl/zclock_pkg.sv
// Shared helpers for the Z80 clock generator: default sizing, mode clamping
// and the per-mode div_cnt slot mask.
package zclock_pkg;

  localparam int unsigned DEF_MODES    = 3;
  localparam int unsigned DEF_MODE_W   = 2;
  localparam int unsigned DEF_STALL_CH = 2;
  localparam int unsigned DEF_CNT_W    = 4;
  localparam int unsigned DEF_IO_MODE  = 1;

  // Width of the free-running grid counter for a given number of modes.
  function automatic int unsigned div_width(input int unsigned modes);
    return modes - 1;
  endfunction

  function automatic int unsigned clamp_mode(input int unsigned req,
                                             input int unsigned modes);
    return (req > modes - 1) ? modes - 1 : req;
  endfunction

  // Low div_cnt bits that must all be ones for an edge slot; the fastest
  // mode yields an empty mask, i.e. a slot every cycle.
  function automatic int unsigned slot_mask(input int unsigned mode,
                                            input int unsigned modes);
    return (32'd1 << (modes - 1 - mode)) - 32'd1;
  endfunction

endpackage

// File: rtl/zclock_stall_ch.sv
// One programmable wait-state channel: a trigger loads the length, which
// then counts down to zero; busy while the count is non-zero.
module zclock_stall_ch #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_trig,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_busy
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments and an async
  // active-low reset so every flop clears the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_trig) begin
      r_cnt <= i_len;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/zclock_gen.sv
// Z80 clock generator: grid-aligned power-of-two speed modes, wait-state
// channels and refresh-time mode commit. Optional macro: ZCLOCK_IO_FALLBACK_EN.
module zclock_gen
  import zclock_pkg::*;
#(
  parameter int unsigned MODES    = DEF_MODES,
  parameter int unsigned MODE_W   = DEF_MODE_W,
  parameter int unsigned STALL_CH = DEF_STALL_CH,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned IO_MODE  = DEF_IO_MODE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [MODE_W-1:0]         turbo_req,
  input  logic                      rfsh_n,
  input  logic                      hold,
  input  logic [STALL_CH-1:0]       stall_trig,
  input  logic [STALL_CH*CNT_W-1:0] stall_len,
  input  logic                      iorq_ext,
  output logic                      zclk_out,
  output logic                      zpos,
  output logic                      zneg,
  output logic [MODE_W-1:0]         turbo_cur,
  output logic                      stall_busy
);

  localparam int unsigned DIV_W = div_width(MODES);

  logic [DIV_W-1:0]    r_div_cnt;
  logic                r_zclk;
  logic                r_zpos;
  logic                r_zneg;
  logic [MODE_W-1:0]   r_turbo_cur;
  logic                r_stall_busy;

  logic [STALL_CH-1:0] w_ch_busy;
  logic [MODE_W-1:0]   w_eff;
  logic [MODE_W-1:0]   w_req_clamped;
  logic [DIV_W-1:0]    w_mask;
  logic                w_slot;
  logic                w_stall;
  logic                w_edge;
  logic                w_pos_nxt;
  logic                w_neg_nxt;

  for (genvar g = 0; g < STALL_CH; g++) begin : g_ch
    zclock_stall_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_trig (stall_trig[g]),
      .i_len  (stall_len[g*CNT_W +: CNT_W]),
      .o_busy (w_ch_busy[g])
    );
  end

  // A trigger stalls its own cycle; the counters cover the following ones.
  assign w_stall = hold | (|stall_trig) | (|w_ch_busy);

`ifdef ZCLOCK_IO_FALLBACK_EN
  always_comb begin
    w_eff = r_turbo_cur;
    if (iorq_ext && (r_turbo_cur > MODE_W'(IO_MODE))) begin
      w_eff = MODE_W'(IO_MODE);
    end
  end
`else
  logic w_unused;
  assign w_eff    = r_turbo_cur;
  assign w_unused = iorq_ext ^ (IO_MODE == 0);
`endif

  assign w_req_clamped = MODE_W'(clamp_mode(int'(turbo_req), MODES));
  assign w_mask        = DIV_W'(slot_mask(int'(w_eff), MODES));
  assign w_slot        = ((r_div_cnt & w_mask) == w_mask);
  assign w_edge        = w_slot & ~w_stall;
  assign w_pos_nxt     = w_edge & ~r_zclk;
  assign w_neg_nxt     = w_edge & r_zclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt    <= '0;
      r_zclk       <= 1'b0;
      r_zpos       <= 1'b0;
      r_zneg       <= 1'b0;
      r_turbo_cur  <= '0;
      r_stall_busy <= 1'b0;
    end else begin
      r_div_cnt    <= r_div_cnt + 1'b1;
      r_zpos       <= w_pos_nxt;
      r_zneg       <= w_neg_nxt;
      r_stall_busy <= (|w_ch_busy) | (|stall_trig);
      if (w_edge) begin
        r_zclk <= ~r_zclk;
      end
      // Speed only changes at a falling Z80 edge inside refresh.
      if (w_neg_nxt && !rfsh_n) begin
        r_turbo_cur <= w_req_clamped;
      end
    end
  end

  assign zclk_out   = r_zclk;
  assign zpos       = r_zpos;
  assign zneg       = r_zneg;
  assign turbo_cur  = r_turbo_cur;
  assign stall_busy = r_stall_busy;

endmodule

// File: tb/tb_zclock_gen.sv
// Scoreboard bench for zclock_gen: stimulus pushes model predictions, a
// monitor pops and compares one full output snapshot per clk.
module tb_zclock_gen;

  localparam int MODES    = 3;
  localparam int MODE_W   = 2;
  localparam int STALL_CH = 2;
  localparam int CNT_W    = 4;
  localparam int IO_MODE  = 1;

  typedef struct packed {
    logic              zclk;
    logic              pos;
    logic              neg;
    logic [MODE_W-1:0] cur;
    logic              busy;
  } obs_t;

  logic                      clk;
  logic                      rst_n;
  logic [MODE_W-1:0]         turbo_req;
  logic                      rfsh_n;
  logic                      hold;
  logic [STALL_CH-1:0]       stall_trig;
  logic [STALL_CH*CNT_W-1:0] stall_len;
  logic                      iorq_ext;
  logic                      zclk_out;
  logic                      zpos;
  logic                      zneg;
  logic [MODE_W-1:0]         turbo_cur;
  logic                      stall_busy;

  zclock_gen #(
    .MODES    (MODES),
    .MODE_W   (MODE_W),
    .STALL_CH (STALL_CH),
    .CNT_W    (CNT_W),
    .IO_MODE  (IO_MODE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .turbo_req  (turbo_req),
    .rfsh_n     (rfsh_n),
    .hold       (hold),
    .stall_trig (stall_trig),
    .stall_len  (stall_len),
    .iorq_ext   (iorq_ext),
    .zclk_out   (zclk_out),
    .zpos       (zpos),
    .zneg       (zneg),
    .turbo_cur  (turbo_cur),
    .stall_busy (stall_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  obs_t sb[$];

  // Reference model: absolute cycle index and per-channel "blocked through"
  // timestamps instead of counters.
  int   m_c;
  int   m_until[STALL_CH];
  logic m_zclk;
  int   m_cur;

  function automatic obs_t sample();
    return obs_t'({zclk_out, zpos, zneg, turbo_cur, stall_busy});
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t: got zclk=%b zpos=%b zneg=%b cur=%0d busy=%b, want zclk=%b zpos=%b zneg=%b cur=%0d busy=%b",
               name, $time, act.zclk, act.pos, act.neg, act.cur, act.busy,
               exp.zclk, exp.pos, exp.neg, exp.cur, exp.busy);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s t=%0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_c    = 0;
    m_zclk = 1'b0;
    m_cur  = 0;
    for (int i = 0; i < STALL_CH; i++) m_until[i] = -1;
  endtask

  // Drive one cycle of inputs and push the outputs expected after its edge.
  task automatic apply(input int req, input bit rfsh, input bit hld,
                       input bit [STALL_CH-1:0] trg, input int len0,
                       input int len1, input bit iorq);
    int   eff, half, lens[STALL_CH];
    bit   slot, active, stall, busy, pos, neg;
    turbo_req  = MODE_W'(req);
    rfsh_n     = rfsh;
    hold       = hld;
    stall_trig = trg;
    stall_len  = {CNT_W'(len1), CNT_W'(len0)};
    iorq_ext   = iorq;
    lens[0] = len0;
    lens[1] = len1;

    eff = m_cur;
`ifdef ZCLOCK_IO_FALLBACK_EN
    if (iorq && eff > IO_MODE) eff = IO_MODE;
`endif
    half = 1 << (MODES - 1 - eff);
    slot = ((m_c % half) == half - 1);
    active = 1'b0;
    for (int i = 0; i < STALL_CH; i++) if (m_until[i] >= m_c) active = 1'b1;
    stall = hld || (trg != 0) || active;
    for (int i = 0; i < STALL_CH; i++) if (trg[i]) m_until[i] = m_c + lens[i];
    busy = active || (trg != 0);
    pos = 1'b0;
    neg = 1'b0;
    if (slot && !stall) begin
      if (m_zclk) neg = 1'b1;
      else        pos = 1'b1;
      m_zclk = ~m_zclk;
    end
    if (neg && !rfsh) m_cur = (req > MODES - 1) ? MODES - 1 : req;
    sb.push_back(obs_t'({m_zclk, pos, neg, MODE_W'(m_cur), busy}));
    m_c++;
  endtask

  task automatic step(input int req, input bit rfsh, input bit hld,
                      input bit [STALL_CH-1:0] trg, input int len0,
                      input int len1, input bit iorq);
    @(negedge clk);
    apply(req, rfsh, hld, trg, len0, len1, iorq);
  endtask

  // Monitor: one snapshot per clk, sampled 1 time unit after the edge.
  initial begin
    obs_t exp;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb.size() > 0) begin
        exp = sb.pop_front();
        check("cycle", sample(), exp);
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    turbo_req  = '0;
    rfsh_n     = 1'b1;
    hold       = 1'b0;
    stall_trig = '0;
    stall_len  = '0;
    iorq_ext   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("reset_state", sample(), '0);

    @(negedge clk);
    rst_n = 1'b1;
    apply(2, 1, 0, 2'b00, 0, 0, 0);

    // Mode 0 held without refresh, then commit to mode 2 inside refresh.
    repeat (24) step(2, 1, 0, 2'b00, 0, 0, 0);
    repeat (8)  step(2, 0, 0, 2'b00, 0, 0, 0);
    repeat (12) step(2, 1, 0, 2'b00, 0, 0, 0);

    // Single channel stall, len 3.
    step(2, 1, 0, 2'b01, 3, 0, 0);
    repeat (8) step(2, 1, 0, 2'b00, 0, 0, 0);

    // Two channels together, then a ch0 retrigger two cycles later.
    step(2, 1, 0, 2'b11, 2, 5, 0);
    step(2, 1, 0, 2'b00, 0, 0, 0);
    step(2, 1, 0, 2'b01, 5, 0, 0);
    repeat (10) step(2, 1, 0, 2'b00, 0, 0, 0);

    // Hold overlapping a channel, then external IO in mode 2.
    step(2, 1, 1, 2'b10, 0, 2, 0);
    repeat (5) step(2, 1, 1, 2'b00, 0, 0, 0);
    repeat (16) step(2, 1, 0, 2'b00, 0, 0, 1);

    // Back to mode 0, then reset mid-stall with zclk_out high.
    repeat (8) step(0, 0, 0, 2'b00, 0, 0, 0);
    repeat (16) step(0, 1, 0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 16 && !m_zclk; i++) step(0, 1, 0, 2'b00, 0, 0, 0);
    check_int("zclk_high_before_reset", int'(m_zclk), 1);
    step(0, 1, 0, 2'b01, 15, 0, 0);
    repeat (2) step(0, 1, 0, 2'b00, 0, 0, 0);
    @(posedge clk);
    #2;
    check("pre_reset_high", sample(), obs_t'({1'b1, 1'b0, 1'b0, 2'd0, 1'b1}));
    rst_n = 1'b0;
    #1;
    check("async_reset", sample(), '0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply(2, 1, 0, 2'b00, 0, 0, 0);
    repeat (20) step(2, 1, 0, 2'b00, 0, 0, 0);

    // Randomised traffic.
    repeat (3000) begin
      bit [STALL_CH-1:0] trg;
      for (int i = 0; i < STALL_CH; i++) trg[i] = ($urandom_range(0, 11) == 0);
      step($urandom_range(0, 3), $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, trg,
           $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 1) != 0);
    end

    repeat (3) @(posedge clk);
    #2;
    check_int("scoreboard_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
